// File: rtl/ring_phase_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ring_phase_decoder
// Purpose  : Decodes the one-hot ring state into a phase index and tracks lock.
// Revision : 1.0
// ============================================================================
module ring_phase_decoder #(
    parameter int STAGES     = 4,
    parameter int IDXW       = 2,
    parameter int REV_W      = 8,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [STAGES-1:0] i_ring_in,
    input  logic              i_step,
    output logic [IDXW-1:0]   o_phase,
    output logic              o_phase_vld,
    output logic              o_locked,
    output logic              o_onehot_err,
    output logic              o_seq_err,
    output logic [REV_W-1:0]  o_rev_cnt,
    output logic              o_rev_tick
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [IDXW-1:0] c_last_idx = IDXW'(STAGES - 1);
    localparam logic [3:0]      c_lock     = 4'(LOCK_CNT);
    localparam logic [3:0]      c_unlock   = 4'(UNLOCK_CNT);

    state_t            r_state, w_state_nxt;
    logic [IDXW-1:0]   r_phase, w_phase_nxt;
    logic [3:0]        r_good, w_good_nxt;
    logic [3:0]        r_bad, w_bad_nxt;
    logic [REV_W-1:0]  r_rev, w_rev_nxt;
    logic              r_phase_vld, w_phase_vld_nxt;
    logic              r_oh_err, w_oh_err_nxt;
    logic              r_seq_err, w_seq_err_nxt;
    logic              r_rev_tick, w_rev_tick_nxt;

    logic [4:0]        w_ones;
    logic [IDXW-1:0]   w_idx;
    logic [IDXW-1:0]   w_exp;
    logic              w_onehot;
    logic              w_good;
    logic [3:0]        w_good_inc;
    logic [3:0]        w_bad_inc;

    always_comb begin
        w_ones = '0;
        w_idx  = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (i_ring_in[i]) begin
                w_ones = w_ones + 5'd1;
                w_idx  = IDXW'(i);
            end
        end
    end

    assign w_onehot   = (w_ones == 5'd1);
    assign w_exp      = (r_phase == c_last_idx) ? '0 : r_phase + IDXW'(1);
    assign w_good     = w_onehot && (w_idx == w_exp);
    assign w_good_inc = (r_good == 4'd15) ? 4'd15 : r_good + 4'd1;
    assign w_bad_inc  = (r_bad == 4'd15) ? 4'd15 : r_bad + 4'd1;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state     <= ST_HUNT;
            r_phase     <= '0;
            r_good      <= '0;
            r_bad       <= '0;
            r_rev       <= '0;
            r_phase_vld <= 1'b0;
            r_oh_err    <= 1'b0;
            r_seq_err   <= 1'b0;
            r_rev_tick  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_good      <= w_good_nxt;
            r_bad       <= w_bad_nxt;
            r_rev       <= w_rev_nxt;
            r_phase_vld <= w_phase_vld_nxt;
            r_oh_err    <= w_oh_err_nxt;
            r_seq_err   <= w_seq_err_nxt;
            r_rev_tick  <= w_rev_tick_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_phase_nxt     = r_phase;
        w_good_nxt      = r_good;
        w_bad_nxt       = r_bad;
        w_rev_nxt       = r_rev;
        w_phase_vld_nxt = 1'b0;
        w_oh_err_nxt    = 1'b0;
        w_seq_err_nxt   = 1'b0;
        w_rev_tick_nxt  = 1'b0;

        if (i_step) begin
            // Any clean one-hot sample re-references the phase, whatever the state.
            if (w_onehot) begin
                w_phase_nxt     = w_idx;
                w_phase_vld_nxt = 1'b1;
            end else begin
                w_oh_err_nxt = 1'b1;
            end

            case (r_state)
                ST_HUNT: begin
                    if (w_onehot) begin
                        w_good_nxt = 4'd1;
                        if (c_lock == 4'd1) begin
                            w_state_nxt = ST_LOCKED;
                            w_bad_nxt   = 4'd0;
                        end else begin
                            w_state_nxt = ST_SYNC;
                        end
                    end
                end
                ST_SYNC: begin
                    if (w_good) begin
                        w_good_nxt = w_good_inc;
                        if (w_good_inc == c_lock) begin
                            w_state_nxt = ST_LOCKED;
                            w_bad_nxt   = 4'd0;
                        end
                    end else if (w_onehot) begin
                        w_seq_err_nxt = 1'b1;
                        w_good_nxt    = 4'd1;
                    end else begin
                        w_state_nxt = ST_HUNT;
                        w_good_nxt  = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (w_good) begin
                        w_bad_nxt = 4'd0;
                        if (r_phase == c_last_idx) begin
                            w_rev_nxt      = r_rev + REV_W'(1);
                            w_rev_tick_nxt = 1'b1;
                        end
                    end else begin
                        w_seq_err_nxt = w_onehot;
                        w_bad_nxt     = w_bad_inc;
                        if (w_bad_inc == c_unlock) begin
                            w_state_nxt = ST_HUNT;
                            w_good_nxt  = 4'd0;
                            w_bad_nxt   = 4'd0;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_HUNT;
                    w_good_nxt  = 4'd0;
                    w_bad_nxt   = 4'd0;
                end
            endcase
        end
    end

    assign o_phase      = r_phase;
    assign o_phase_vld  = r_phase_vld;
    assign o_locked     = (r_state == ST_LOCKED);
    assign o_onehot_err = r_oh_err;
    assign o_seq_err    = r_seq_err;
    assign o_rev_cnt    = r_rev;
    assign o_rev_tick   = r_rev_tick;

endmodule
`default_nettype wire

// File: tb/tb_ring_phase_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ring_phase_decoder
// Purpose  : Directed vectors with a queued scoreboard for ring_phase_decoder.
// Revision : 1.0
// ============================================================================
module tb_ring_phase_decoder;

    logic       clk;
    logic       r_rstn;
    logic [3:0] r_ring;
    logic       r_step;
    logic [1:0] w_phase;
    logic       w_phase_vld;
    logic       w_locked;
    logic       w_oh_err;
    logic       w_seq_err;
    logic [1:0] w_rev_cnt;
    logic       w_rev_tick;

    int tests_run;
    int tests_failed;
    int vec_n;

    // Record layout: {phase[1:0], phase_vld, locked, onehot_err, seq_err, rev_cnt[1:0], rev_tick}
    logic [8:0] q_exp[$];
    int         q_id[$];

    ring_phase_decoder #(
        .STAGES     (4),
        .IDXW       (2),
        .REV_W      (2),
        .LOCK_CNT   (4),
        .UNLOCK_CNT (2)
    ) u_dut (
        .i_clk        (clk),
        .i_rstn       (r_rstn),
        .i_ring_in    (r_ring),
        .i_step       (r_step),
        .o_phase      (w_phase),
        .o_phase_vld  (w_phase_vld),
        .o_locked     (w_locked),
        .o_onehot_err (w_oh_err),
        .o_seq_err    (w_seq_err),
        .o_rev_cnt    (w_rev_cnt),
        .o_rev_tick   (w_rev_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic v(input logic rstn, input logic step, input logic [3:0] ring,
                     input logic [1:0] ph, input logic vld, input logic lk,
                     input logic oh, input logic sq, input logic [1:0] rv,
                     input logic tk);
        @(negedge clk);
        r_rstn = rstn;
        r_step = step;
        r_ring = ring;
        q_exp.push_back({ph, vld, lk, oh, sq, rv, tk});
        q_id.push_back(vec_n);
        vec_n++;
    endtask

    // One locked revolution starting at phase 0, ending on the 3 -> 0 tick.
    task automatic revol(input logic [1:0] rv_after);
        logic [1:0] rv_before;
        rv_before = rv_after - 2'd1;
        v(1, 1, 4'b0010, 2'd1, 1, 1, 0, 0, rv_before, 0);
        v(1, 1, 4'b0100, 2'd2, 1, 1, 0, 0, rv_before, 0);
        v(1, 1, 4'b1000, 2'd3, 1, 1, 0, 0, rv_before, 0);
        v(1, 1, 4'b0001, 2'd0, 1, 1, 0, 0, rv_after,  1);
    endtask

    initial begin : monitor
        logic [8:0] exp_v;
        logic [8:0] act_v;
        int         id;
        forever begin
            @(posedge clk);
            #1;
            if (q_exp.size() > 0) begin
                exp_v = q_exp.pop_front();
                id    = q_id.pop_front();
                act_v = {w_phase, w_phase_vld, w_locked, w_oh_err, w_seq_err,
                         w_rev_cnt, w_rev_tick};
                tests_run++;
                if (act_v !== exp_v) begin
                    tests_failed++;
                    $display("FAIL vec%0d {ph,vld,lk,oh,seq,rev,tick}: got %b required %b",
                             id, act_v, exp_v);
                end
            end
        end
    end

    initial begin : stimulus
        int guard;
        tests_run    = 0;
        tests_failed = 0;
        vec_n        = 0;
        r_rstn       = 1'b0;
        r_step       = 1'b0;
        r_ring       = 4'b0000;

        // Reset wins over a concurrent STEP
        v(0, 1, 4'b0010, 2'd0, 0, 0, 0, 0, 2'd0, 0);
        v(1, 1, 4'b0100, 2'd2, 1, 0, 0, 0, 2'd0, 0);

        // Lock from a clean start
        v(0, 0, 4'b0000, 2'd0, 0, 0, 0, 0, 2'd0, 0);
        v(1, 1, 4'b0001, 2'd0, 1, 0, 0, 0, 2'd0, 0);
        v(1, 1, 4'b0010, 2'd1, 1, 0, 0, 0, 2'd0, 0);
        v(1, 1, 4'b0100, 2'd2, 1, 0, 0, 0, 2'd0, 0);
        v(1, 1, 4'b1000, 2'd3, 1, 1, 0, 0, 2'd0, 0);

        // Revolutions, including the 2-bit counter wrap
        v(1, 1, 4'b0001, 2'd0, 1, 1, 0, 0, 2'd1, 0 | 1'b1);
        revol(2'd2);
        v(1, 0, 4'b0001, 2'd0, 0, 1, 0, 0, 2'd2, 0);
        revol(2'd3);
        revol(2'd0);

        // Sequence error while locked, then a good sample that also completes a revolution
        v(1, 1, 4'b0010, 2'd1, 1, 1, 0, 0, 2'd0, 0);
        v(1, 1, 4'b1000, 2'd3, 1, 1, 0, 1, 2'd0, 0);
        v(1, 1, 4'b0001, 2'd0, 1, 1, 0, 0, 2'd1, 1);

        // Two malformed samples unlock; PHASE and REV_CNT hold
        v(1, 1, 4'b0000, 2'd0, 0, 1, 1, 0, 2'd1, 0);
        v(1, 1, 4'b0110, 2'd0, 0, 0, 1, 0, 2'd1, 0);

        // HUNT never flags SEQ_ERR; malformed sample in SYNC drops back to HUNT
        v(1, 1, 4'b0100, 2'd2, 1, 0, 0, 0, 2'd1, 0);
        v(1, 1, 4'b1100, 2'd2, 0, 0, 1, 0, 2'd1, 0);

        // SYNC restart on a stall
        v(0, 0, 4'b0000, 2'd0, 0, 0, 0, 0, 2'd0, 0);
        v(1, 1, 4'b0001, 2'd0, 1, 0, 0, 0, 2'd0, 0);
        v(1, 1, 4'b0010, 2'd1, 1, 0, 0, 0, 2'd0, 0);
        v(1, 1, 4'b0010, 2'd1, 1, 0, 0, 1, 2'd0, 0);
        v(1, 1, 4'b0100, 2'd2, 1, 0, 0, 0, 2'd0, 0);
        v(1, 1, 4'b1000, 2'd3, 1, 0, 0, 0, 2'd0, 0);
        v(1, 1, 4'b0001, 2'd0, 1, 1, 0, 0, 2'd0, 0);

        // Stall while locked, then reset during LOCKED, then first STEP after release
        v(1, 1, 4'b0001, 2'd0, 1, 1, 0, 1, 2'd0, 0);
        v(0, 1, 4'b0010, 2'd0, 0, 0, 0, 0, 2'd0, 0);
        v(1, 1, 4'b0001, 2'd0, 1, 0, 0, 0, 2'd0, 0);

        @(negedge clk);
        r_step = 1'b0;

        guard = 0;
        while (q_exp.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (q_exp.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d records left, required 0", q_exp.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
